// File: rtl/decode_if.sv
// Handshake and decoded-field bundle between an instruction source, the decode
// stage and its downstream consumer.
interface decode_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [XLEN-1:0] out_imm;
    logic [3:0]      out_alu_op;
    logic            out_use_imm;
    logic            out_mem_rd;
    logic            out_mem_wr;
    logic            out_illegal;

    // Environment side: produces instructions and consumes decoded words.
    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_rd, out_rs1, out_rs2, out_imm,
               out_alu_op, out_use_imm, out_mem_rd, out_mem_wr, out_illegal
    );

    // Decode stage side.
    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_rd, out_rs1, out_rs2, out_imm,
               out_alu_op, out_use_imm, out_mem_rd, out_mem_wr, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode stage: small input FIFO with empty-path bypass feeding a
// registered decode output that holds steady under downstream backpressure.
module decode_stage #(
    parameter int XLEN           = 32,
    parameter int FIFO_DEPTH     = 2,
    parameter int ENABLE_IMM_ALU = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    decode_if.slave                     bus,
    output logic [$clog2(FIFO_DEPTH):0] occupancy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    if (XLEN < 12) begin : g_bad_xlen
        $error("decode_stage: XLEN must be at least 12");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("decode_stage: FIFO_DEPTH must be a power of two and at least 2");
    end

    typedef struct packed {
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu_op;
        logic            use_imm;
        logic            mem_rd;
        logic            mem_wr;
        logic            illegal;
    } dec_t;

    function automatic logic signed [XLEN-1:0] sext12(input logic [11:0] v);
        logic signed [11:0] s;
        s = signed'(v);
        return XLEN'(s);
    endfunction

    function automatic dec_t decode(input logic [31:0] w);
        dec_t d;
        d = '0;
        case (w[6:0])
            7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7, 7'd8, 7'd9, 7'd10: begin
                // Register-register ops: the opcode value is the ALU op.
                d.rd     = w[11:7];
                d.rs1    = w[19:15];
                d.rs2    = w[24:20];
                d.alu_op = w[3:0];
            end
            7'd11: begin
                d.rd      = w[11:7];
                d.rs1     = w[19:15];
                d.imm     = sext12(w[31:20]);
                d.alu_op  = 4'd11;
                d.mem_rd  = 1'b1;
                d.use_imm = 1'b1;
            end
            7'd12: begin
                d.rs1     = w[19:15];
                d.rs2     = w[24:20];
                d.imm     = sext12({w[31:25], w[11:7]});
                d.alu_op  = 4'd12;
                d.mem_wr  = 1'b1;
                d.use_imm = 1'b1;
            end
            7'd13, 7'd14, 7'd15, 7'd16: begin
                if (ENABLE_IMM_ALU != 0) begin
                    d.rd      = w[11:7];
                    d.rs1     = w[19:15];
                    d.imm     = sext12(w[31:20]);
                    d.use_imm = 1'b1;
                    case (w[2:0])
                        3'd5:    d.alu_op = 4'd1;
                        3'd6:    d.alu_op = 4'd3;
                        3'd7:    d.alu_op = 4'd4;
                        default: d.alu_op = 4'd5;
                    endcase
                end else begin
                    d.illegal = 1'b1;
                end
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    dec_t             out_q, out_d;
    logic             rdy_en_q;

    logic in_ready;
    logic accept;
    logic load;
    logic pop;
    logic bypass;
    logic push;

    // rdy_en_q keeps in_ready low during reset and releases it at the first edge after.
    assign in_ready = rdy_en_q && (count_q < DEPTH_C);
    assign accept   = bus.in_valid && in_ready && !flush;
    assign load     = !out_valid_q || bus.out_ready;
    assign pop      = load && (count_q != '0) && !flush;
    assign bypass   = load && (count_q == '0) && accept;
    assign push     = accept && !bypass;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (load) begin
                // The FIFO head always wins over the bypass to keep arrival order.
                if (count_q != '0) begin
                    out_d       = decode(mem_q[rd_ptr_q]);
                    out_valid_d = 1'b1;
                end else if (accept) begin
                    out_d       = decode(bus.in_instr);
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            rdy_en_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            rdy_en_q    <= 1'b1;
        end
    end

    // Buffer storage carries no reset; count and pointers define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_instr;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_rd      = out_q.rd;
    assign bus.out_rs1     = out_q.rs1;
    assign bus.out_rs2     = out_q.rs2;
    assign bus.out_imm     = out_q.imm;
    assign bus.out_alu_op  = out_q.alu_op;
    assign bus.out_use_imm = out_q.use_imm;
    assign bus.out_mem_rd  = out_q.mem_rd;
    assign bus.out_mem_wr  = out_q.mem_wr;
    assign bus.out_illegal = out_q.illegal;
    assign occupancy       = count_q;
endmodule
